// File: rtl/alu_issue.sv
// Decode-and-issue stage for RV32I OP / OP-IMM words feeding the ALU.
// Optional macro WB_BYPASS_EN: writeback data bypasses to operands read in the same cycle.
module alu_issue #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_optype,
  output logic [2:0]       out_aluop,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_data1,
  output logic [XLEN-1:0]  out_data2,
  output logic [4:0]       out_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_Z    = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [XLEN-1:0]  r_rf [32];
  logic             r_valid;
  logic [6:0]       r_optype;
  logic [2:0]       r_aluop;
  logic [6:0]       r_funct7;
  logic [XLEN-1:0]  r_data1;
  logic [XLEN-1:0]  r_data2;
  logic [4:0]       r_rd;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_wb;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_is_op;
  logic            w_is_sh;
  logic            w_is_ar;
  logic            w_legal;
  logic [6:0]      w_f7_out;
  logic [XLEN-1:0] w_data2;
  logic            w_acc;
  logic            w_load;
  logic            w_bad;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];
  assign w_wb  = wb_en && (wb_addr != 5'd0);

`ifdef WB_BYPASS_EN
  always_comb begin
    w_rd1 = r_rf[w_rs1];
    w_rd2 = r_rf[w_rs2];
    if (w_wb && wb_addr == w_rs1) w_rd1 = wb_data;
    if (w_wb && wb_addr == w_rs2) w_rd2 = wb_data;
    if (w_rs1 == 5'd0) w_rd1 = '0;
    if (w_rs2 == 5'd0) w_rd2 = '0;
  end
`else
  always_comb begin
    w_rd1 = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
    w_rd2 = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
  end
`endif

  assign w_is_op = (w_opc == OPC_OP);
  assign w_is_sh = (w_opc == OPC_IMM) && (w_f3 == 3'b001 || w_f3 == 3'b101);
  assign w_is_ar = (w_opc == OPC_IMM) && !w_is_sh;

  always_comb begin
    w_legal  = 1'b0;
    w_f7_out = F7_Z;
    w_data2  = w_rd2;
    unique case (1'b1)
      w_is_op: begin
        w_f7_out = w_f7;
        w_legal  = (w_f7 == F7_Z) ||
                   (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101));
      end
      w_is_sh: begin
        w_f7_out = w_f7;
        w_data2  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        w_legal  = (w_f7 == F7_Z) || (w_f7 == F7_ALT && w_f3 == 3'b101);
      end
      w_is_ar: begin
        w_data2 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        w_legal = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready = !r_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_load   = w_acc && w_legal;
  assign w_bad    = w_acc && !w_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_wb) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_optype  <= '0;
      r_aluop   <= '0;
      r_funct7  <= '0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_load) begin
        r_valid  <= 1'b1;
        r_optype <= w_opc;
        r_aluop  <= w_f3;
        r_funct7 <= w_f7_out;
        r_data1  <= w_rd1;
        r_data2  <= w_data2;
        r_rd     <= in_instr[11:7];
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      r_illegal <= w_bad;
      // Saturate rather than wrap so a flood of bad words stays visible.
      if (w_bad && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid   = r_valid;
  assign out_optype  = r_optype;
  assign out_aluop   = r_aluop;
  assign out_funct7  = r_funct7;
  assign out_data1   = r_data1;
  assign out_data2   = r_data2;
  assign out_rd      = r_rd;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_cnt;

endmodule
